// File: rtl/maint_iseq_executor.sv
// Maintenance instruction executor: takes the DDR command bus when the host iseq path is idle,
// then decodes and runs sequencer instructions (DDR commands, WAIT, bus direction, END_ISEQ).
module maint_iseq_executor #(
  parameter int CS_WIDTH   = 1,
  parameter int ROW_WIDTH  = 15,
  parameter int BANK_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  maint_instr_en,
  input  logic [31:0]           maint_instr,
  output logic                  maint_ack,
  input  logic                  host_idle,
  output logic                  maint_busy,
  output logic                  ddr_cke,
  output logic [CS_WIDTH-1:0]   ddr_cs_n,
  output logic                  ddr_ras_n,
  output logic                  ddr_cas_n,
  output logic                  ddr_we_n,
  output logic [ROW_WIDTH-1:0]  ddr_addr,
  output logic [BANK_WIDTH-1:0] ddr_ba,
  output logic [1:0]            bus_dir,
  output logic                  iseq_done,
  output logic                  bad_opcode
);

  // Instruction layout: opcode [31:28]; DDR command fields below.
  localparam logic [3:0] OP_DDR_INSTR  = 4'h1;
  localparam logic [3:0] OP_SET_BUSDIR = 4'h2;
  localparam logic [3:0] OP_WAIT       = 4'h3;
  localparam logic [3:0] OP_END_ISEQ   = 4'h4;
  localparam int BANK_OFFSET = 15;
  localparam int CS_OFFSET   = 18;
  localparam int WE_BIT      = 24;
  localparam int CAS_BIT     = 25;
  localparam int RAS_BIT     = 26;
  localparam int CKE_BIT     = 27;
  localparam logic [1:0] BUS_DIR_READ = 2'b00;

  // Handshake: an instruction is presented while maint_instr_en=1 and is consumed in the
  // cycle maint_ack=1; END_ISEQ and aborts are never acked.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAITING} state_t;

  state_t      state, state_nx;
  logic [27:0] cnt, cnt_nx;
  logic        issue_cmd, set_dir, set_bad;
  logic [3:0]  opcode;
  logic [27:0] wait_n;

  assign opcode     = maint_instr[31:28];
  assign wait_n     = maint_instr[27:0];
  assign maint_busy = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    maint_ack = 1'b0;
    iseq_done = 1'b0;
    issue_cmd = 1'b0;
    set_dir   = 1'b0;
    set_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (maint_instr_en && host_idle) state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (!maint_instr_en) begin
          state_nx = S_IDLE;
        end else begin
          case (opcode)
            OP_DDR_INSTR: begin
              maint_ack = 1'b1;
              issue_cmd = 1'b1;
            end
            OP_SET_BUSDIR: begin
              maint_ack = 1'b1;
              set_dir   = 1'b1;
            end
            OP_WAIT: begin
              // The WAIT cycle itself counts, so N cycles means N-1 more in WAITING.
              if (wait_n <= 28'd1) begin
                maint_ack = 1'b1;
              end else begin
                cnt_nx   = wait_n - 28'd1;
                state_nx = S_WAITING;
              end
            end
            OP_END_ISEQ: begin
              iseq_done = 1'b1;
              state_nx  = S_IDLE;
            end
            default: begin
              maint_ack = 1'b1;
              set_bad   = 1'b1;
            end
          endcase
        end
      end
      S_WAITING: begin
        if (!maint_instr_en) begin
          cnt_nx   = 28'd0;
          state_nx = S_IDLE;
        end else if (cnt == 28'd1) begin
          maint_ack = 1'b1;
          cnt_nx    = 28'd0;
          state_nx  = S_EXEC;
        end else begin
          cnt_nx = cnt - 28'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 28'd0;
      ddr_cke    <= 1'b1;
      ddr_cs_n   <= '1;
      ddr_ras_n  <= 1'b1;
      ddr_cas_n  <= 1'b1;
      ddr_we_n   <= 1'b1;
      ddr_addr   <= '0;
      ddr_ba     <= '0;
      bus_dir    <= BUS_DIR_READ;
      bad_opcode <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (issue_cmd) begin
        ddr_cke   <= maint_instr[CKE_BIT];
        ddr_cs_n  <= maint_instr[CS_OFFSET +: CS_WIDTH];
        ddr_ras_n <= maint_instr[RAS_BIT];
        ddr_cas_n <= maint_instr[CAS_BIT];
        ddr_we_n  <= maint_instr[WE_BIT];
        ddr_addr  <= maint_instr[ROW_WIDTH-1:0];
        ddr_ba    <= maint_instr[BANK_OFFSET +: BANK_WIDTH];
      end else begin
        // NOP: address/bank and CKE keep their last values.
        ddr_cs_n  <= '1;
        ddr_ras_n <= 1'b1;
        ddr_cas_n <= 1'b1;
        ddr_we_n  <= 1'b1;
      end
      if (set_dir) bus_dir <= maint_instr[1:0];
      if (set_bad) bad_opcode <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maint_iseq_executor.sv
// Directed bench for maint_iseq_executor: drivers push expected acks, DDR commands and
// iseq_done pulses into queues; a negedge monitor pops and compares them.
module tb_maint_iseq_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic        maint_instr_en;
  logic [31:0] maint_instr;
  logic        maint_ack;
  logic        host_idle;
  logic        maint_busy;
  logic        ddr_cke;
  logic [0:0]  ddr_cs_n;
  logic        ddr_ras_n, ddr_cas_n, ddr_we_n;
  logic [14:0] ddr_addr;
  logic [2:0]  ddr_ba;
  logic [1:0]  bus_dir;
  logic        iseq_done;
  logic        bad_opcode;

  // Hand-encoded instructions
  localparam logic [31:0] I_PRE     = 32'h1A00_0400; // cke=1 ras=0 cas=1 we=0 cs=0 A10=1
  localparam logic [31:0] I_REF     = 32'h1900_0000; // cke=1 ras=0 cas=0 we=1 cs=0
  localparam logic [31:0] I_WAIT0   = 32'h3000_0000;
  localparam logic [31:0] I_WAIT1   = 32'h3000_0001;
  localparam logic [31:0] I_WAIT4   = 32'h3000_0004;
  localparam logic [31:0] I_WAIT5   = 32'h3000_0005;
  localparam logic [31:0] I_WAIT88  = 32'h3000_0058;
  localparam logic [31:0] I_WAIT100 = 32'h3000_0064;
  localparam logic [31:0] I_DIR_WR  = 32'h2000_0001;
  localparam logic [31:0] I_BAD     = 32'hF000_0000;
  localparam logic [31:0] I_END     = 32'h4000_0000;
  localparam logic [1:0]  DIR_READ  = 2'b00;
  localparam logic [1:0]  DIR_WRITE = 2'b01;
  // {cke, cs_n, ras_n, cas_n, we_n, ba, addr}
  localparam logic [22:0] PRE_EXP = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 15'h0400};
  localparam logic [22:0] REF_EXP = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 15'h0000};
  localparam logic [22:0] NONE    = 23'd0;

  maint_iseq_executor #(.CS_WIDTH(1), .ROW_WIDTH(15), .BANK_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .maint_instr_en(maint_instr_en), .maint_instr(maint_instr), .maint_ack(maint_ack),
    .host_idle(host_idle), .maint_busy(maint_busy),
    .ddr_cke(ddr_cke), .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n),
    .ddr_we_n(ddr_we_n), .ddr_addr(ddr_addr), .ddr_ba(ddr_ba),
    .bus_dir(bus_dir), .iseq_done(iseq_done), .bad_opcode(bad_opcode)
  );

  // Clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [63:0] ack_q[$];   // {cycle, instr}
  logic [54:0] ddr_q[$];   // {cycle, command fields}
  logic [31:0] done_q[$];  // cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(maint_busy), 32'd0);
    check({tag, "_ack"}, 32'(maint_ack), 32'd0);
    check({tag, "_done"}, 32'(iseq_done), 32'd0);
    check({tag, "_bad"}, 32'(bad_opcode), 32'd0);
    check({tag, "_cmd"}, 32'({ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'h1F);
    check({tag, "_addr_ba"}, 32'({ddr_ba, ddr_addr}), 32'd0);
    check({tag, "_bus_dir"}, 32'(bus_dir), 32'(DIR_READ));
  endtask

  // Monitor: every ack / DDR command / done pulse must match the head of its queue.
  logic [63:0] ea;
  logic [54:0] ed;
  logic [31:0] ee;
  always @(negedge clk) begin
    if (!rst) begin
      if (maint_ack) begin
        tests++;
        if (ack_q.size() == 0) begin
          fails++;
          $display("FAIL ack_unexpected: got ack at cycle %0d instr %h, expected none", cyc, maint_instr);
        end else begin
          ea = ack_q.pop_front();
          if ({32'(cyc), maint_instr} !== ea) begin
            fails++;
            $display("FAIL ack: got cycle %0d instr %h, expected cycle %0d instr %h",
                     cyc, maint_instr, ea[63:32], ea[31:0]);
          end
        end
      end
      if (ddr_cs_n !== 1'b1) begin
        tests++;
        if (ddr_q.size() == 0) begin
          fails++;
          $display("FAIL ddr_unexpected: got command at cycle %0d, expected NOP", cyc);
        end else begin
          ed = ddr_q.pop_front();
          if ({32'(cyc), ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_addr} !== ed) begin
            fails++;
            $display("FAIL ddr_cmd: got cycle %0d cmd %h, expected cycle %0d cmd %h", cyc,
                     {ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_addr},
                     ed[54:23], ed[22:0]);
          end
        end
      end
      if (iseq_done) begin
        tests++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got iseq_done at cycle %0d, expected none", cyc);
        end else begin
          ee = done_q.pop_front();
          if (32'(cyc) !== ee) begin
            fails++;
            $display("FAIL iseq_done: got cycle %0d, expected cycle %0d", cyc, ee);
          end
        end
      end
    end
  end

  // Drivers: called at posedge+1 with the DUT in EXEC.
  task automatic issue(input logic [31:0] instr, input int lat, input bit is_ddr,
                       input logic [22:0] ddr_exp);
    bit got;
    maint_instr    = instr;
    maint_instr_en = 1'b1;
    ack_q.push_back({32'(cyc + lat), instr});
    if (is_ddr) ddr_q.push_back({32'(cyc + 1), ddr_exp});
    got = 1'b0;
    for (int i = 0; i <= lat + 3; i++) begin
      @(negedge clk);
      if (maint_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got no ack for instr %h, expected one within %0d cycles", instr, lat);
    end
    @(posedge clk); #1;
  endtask

  // IDLE -> EXEC: returns at posedge+1 of the first EXEC cycle.
  task automatic start_seq(input logic [31:0] first);
    host_idle      = 1'b1;
    maint_instr_en = 1'b1;
    maint_instr    = first;
    @(negedge clk);
    check("idle_not_busy", 32'(maint_busy), 32'd0);
    @(posedge clk); #1;
    check("exec_busy", 32'(maint_busy), 32'd1);
  endtask

  task automatic end_seq();
    maint_instr    = I_END;
    maint_instr_en = 1'b1;
    done_q.push_back(32'(cyc));
    @(negedge clk);
    check("end_busy_still", 32'(maint_busy), 32'd1);
    @(posedge clk); #1;
    maint_instr_en = 1'b0;
    @(negedge clk);
    check("end_busy_drop", 32'(maint_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; maint_instr_en = 1'b0; maint_instr = 32'd0; host_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;

    // Host busy: instruction presented but bus not granted
    maint_instr_en = 1'b1;
    maint_instr    = I_PRE;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("host_busy_no_grant", 32'(maint_busy), 32'd0);
      @(posedge clk); #1;
    end

    // Precharge-all, WAIT boundaries, bus direction, bad opcode
    start_seq(I_PRE);
    issue(I_PRE, 0, 1'b1, PRE_EXP);
    issue(I_WAIT0, 0, 1'b0, NONE);
    check("nop_after_pre", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'hF);
    check("cke_holds", 32'(ddr_cke), 32'd1);
    issue(I_WAIT1, 0, 1'b0, NONE);
    issue(I_WAIT5, 4, 1'b0, NONE);
    check("bus_dir_before", 32'(bus_dir), 32'(DIR_READ));
    issue(I_DIR_WR, 0, 1'b0, NONE);
    check("bus_dir_write", 32'(bus_dir), 32'(DIR_WRITE));
    check("bad_before", 32'(bad_opcode), 32'd0);
    issue(I_BAD, 0, 1'b0, NONE);
    check("bad_set", 32'(bad_opcode), 32'd1);
    issue(I_WAIT0, 0, 1'b0, NONE);
    check("bad_sticky", 32'(bad_opcode), 32'd1);
    end_seq();
    check("bad_sticky_idle", 32'(bad_opcode), 32'd1);

    // Autorefresh sequence
    start_seq(I_PRE);
    issue(I_PRE, 0, 1'b1, PRE_EXP);
    issue(I_WAIT4, 3, 1'b0, NONE);
    issue(I_REF, 0, 1'b1, REF_EXP);
    issue(I_WAIT88, 87, 1'b0, NONE);
    end_seq();

    // Abort by dropping maint_instr_en during WAIT
    start_seq(I_WAIT5);
    @(posedge clk); #1;
    maint_instr_en = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(maint_busy), 32'd0);

    // Reset during WAIT 100 at count 50
    start_seq(I_WAIT100);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1; maint_instr_en = 1'b0; host_idle = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midwait_reset");
    repeat (110) @(posedge clk);
    #1;

    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("ddr_q_empty", 32'(ddr_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
